// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test controller.
// Holds the FSM state type, the ALU op sequence and the LFSR/MISR polynomials.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_OPS = 5;

  // Element i is the ALU control code applied at op_idx i.
  localparam logic [NUM_OPS-1:0][3:0] OP_CODES = {
    4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000
  };

  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam logic [31:0] MISR_MASK   = 32'h0040_0007;
  localparam logic [31:0] OPERAND_XOR = 32'h5A5A_5A5A;

  // Operand B is a half-word swap of the LFSR state, decorrelated by a fixed XOR.
  function automatic logic [31:0] operand_b(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ OPERAND_XOR;
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Galois step register with load, enable, feedback mask and data injection.
// Used as the right-shifting stimulus LFSR and as the left-shifting response MISR.
module bist_lfsr32 #(
  parameter bit SHIFT_LEFT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        en,
  input  logic [31:0] mask,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic [31:0] q_next
);

  // NOTE: q_next is assigned on every path of this always_comb, so no latch is inferred.
  always_comb begin
    q_next = '0;
    if (SHIFT_LEFT) begin
      q_next = {q[30:0], 1'b0} ^ (q[31] ? mask : 32'h0) ^ data;
    end else begin
      q_next = {1'b0, q[31:1]} ^ (q[0] ? mask : 32'h0) ^ data;
    end
  end

  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_value;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/alu_bist.sv
// BIST controller for the 32-bit ALU: drives pseudo-random operands under every op,
// compacts the responses into a MISR and compares the final signature to a golden value.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int          N_VECTORS  = 256,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        zero_flag,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);

  localparam int CNT_W = $clog2(N_VECTORS + 1);
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(N_VECTORS - 1);

  state_t           state;
  logic [2:0]       op_idx;
  logic [2:0]       op_idx_next;
  logic [CNT_W-1:0] vec_cnt;

  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [31:0] sig_next;
  logic [31:0] lfsr_apply;

  logic running;
  logic start_run;
  logic op_wrap;
  logic last_cycle;

  assign running     = (state == RUN);
  assign start_run   = start && !running;
  assign op_wrap     = running && (op_idx == 3'(NUM_OPS - 1));
  assign last_cycle  = op_wrap && (vec_cnt == LAST_VEC);
  assign op_idx_next = (op_idx == 3'(NUM_OPS - 1)) ? 3'd0 : op_idx + 3'd1;

  // The operand pair for the next cycle comes from the stepped LFSR only on a wrap.
  assign lfsr_apply = op_wrap ? lfsr_next : lfsr;

  bist_lfsr32 #(
    .SHIFT_LEFT (1'b0)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (start_run),
    .load_value (LFSR_SEED),
    .en         (op_wrap),
    .mask       (LFSR_MASK),
    .data       (32'h0),
    .q          (lfsr),
    .q_next     (lfsr_next)
  );

  bist_lfsr32 #(
    .SHIFT_LEFT (1'b1)
  ) u_misr (
    .clk        (clk),
    .rst        (rst),
    .load       (start_run),
    .load_value (32'h0),
    .en         (running),
    .mask       (MISR_MASK),
    .data       (alu_result ^ {31'b0, zero_flag}),
    .q          (signature),
    .q_next     (sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_idx      <= '0;
      vec_cnt     <= '0;
      in1         <= '0;
      in2         <= '0;
      alu_control <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            op_idx      <= '0;
            vec_cnt     <= '0;
            in1         <= LFSR_SEED;
            in2         <= operand_b(LFSR_SEED);
            alu_control <= OP_CODES[0];
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
          end
        end
        RUN: begin
          op_idx <= op_idx_next;
          if (op_wrap) begin
            vec_cnt <= vec_cnt + CNT_W'(1);
          end
          if (last_cycle) begin
            state       <= DONE;
            in1         <= '0;
            in2         <= '0;
            alu_control <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= (sig_next == GOLDEN_SIG);
          end else begin
            in1         <= lfsr_apply;
            in2         <= operand_b(lfsr_apply);
            alu_control <= OP_CODES[op_idx_next];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a modelled ALU on the main instance, constant-response
// stubs on two short instances, and a scoreboard of expected vectors per run.
module tb_alu_bist;

  localparam int NV = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic fault;

  logic [31:0] m_in1, m_in2, m_res, m_sig;
  logic [3:0]  m_ctrl;
  logic        m_zero, m_busy, m_done, m_pass;

  logic [31:0] p_in1, p_in2, p_sig;
  logic [3:0]  p_ctrl;
  logic        p_busy, p_done, p_pass;

  logic [31:0] f_in1, f_in2, f_sig;
  logic [3:0]  f_ctrl;
  logic        f_busy, f_done, f_pass;

  logic [3:0] ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  vec_t       sb [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0100: return a - b;
      4'b1000: return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] r,
                                            input logic z);
    return (s << 1) ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ r ^ {31'b0, z};
  endfunction

  assign m_res  = alu_model(m_in1, m_in2, m_ctrl) | (fault ? 32'h0000_0008 : 32'h0);
  assign m_zero = (m_res == 32'h0);

  alu_bist #(.N_VECTORS(NV), .LFSR_SEED(32'h1), .GOLDEN_SIG(32'h0)) u_main (
    .clk(clk), .rst(rst), .start(start), .in1(m_in1), .in2(m_in2), .alu_control(m_ctrl),
    .alu_result(m_res), .zero_flag(m_zero), .busy(m_busy), .done(m_done), .pass(m_pass),
    .signature(m_sig)
  );

  alu_bist #(.N_VECTORS(1), .LFSR_SEED(32'h1), .GOLDEN_SIG(32'h1F)) u_misr_pass (
    .clk(clk), .rst(rst), .start(start), .in1(p_in1), .in2(p_in2), .alu_control(p_ctrl),
    .alu_result(32'h0), .zero_flag(1'b1), .busy(p_busy), .done(p_done), .pass(p_pass),
    .signature(p_sig)
  );

  alu_bist #(.N_VECTORS(1), .LFSR_SEED(32'h1), .GOLDEN_SIG(32'h0)) u_misr_fail (
    .clk(clk), .rst(rst), .start(start), .in1(f_in1), .in2(f_in2), .alu_control(f_ctrl),
    .alu_result(32'h0), .zero_flag(1'b1), .busy(f_busy), .done(f_done), .pass(f_pass),
    .signature(f_sig)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in1"},  m_in1, 32'h0);
    check({tag, "_in2"},  m_in2, 32'h0);
    check({tag, "_ctrl"}, 32'(m_ctrl), 32'h0);
    check({tag, "_busy"}, 32'(m_busy), 32'h0);
    check({tag, "_done"}, 32'(m_done), 32'h0);
    check({tag, "_pass"}, 32'(m_pass), 32'h0);
    check({tag, "_sig"},  m_sig, 32'h0);
    check({tag, "_stub_sig"}, p_sig, 32'h0);
  endtask

  // Pushes the expected vector stream for one run and returns the expected signature.
  task automatic push_run(input bit flt, output logic [31:0] sig_exp);
    logic [31:0] x, s, a, b, r;
    x = 32'h1;
    s = 32'h0;
    for (int v = 0; v < NV; v++) begin
      for (int o = 0; o < 5; o++) begin
        a = x;
        b = {x[15:0], x[31:16]} ^ 32'h5A5A_5A5A;
        sb.push_back(vec_t'{a, b, ops[o]});
        r = alu_model(a, b, ops[o]) | (flt ? 32'h8 : 32'h0);
        s = misr_step(s, r, r == 32'h0);
      end
      x = lfsr_step(x);
    end
    sig_exp = s;
  endtask

  task automatic run_main(input bit flt, input bit start_mid, input bit misr_chk,
                          output logic [31:0] sig_got);
    logic [31:0] sig_exp;
    vec_t        e;
    fault = flt;
    push_run(flt, sig_exp);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 5 * NV; c++) begin
      e = sb.pop_front();
      check("in1", m_in1, e.a);
      check("in2", m_in2, e.b);
      check("alu_control", 32'(m_ctrl), 32'(e.op));
      check("busy_run", 32'(m_busy), 32'h1);
      check("done_run", 32'(m_done), 32'h0);
      if (misr_chk && c >= 1 && c <= 4) begin
        check("misr_step", p_sig, (32'h1 << c) - 32'h1);
        check("stub_busy", 32'(p_busy), 32'h1);
        check("stub_done_early", 32'(p_done), 32'h0);
      end
      if (misr_chk && c == 5) begin
        check("stub_done", 32'(p_done), 32'h1);
        check("stub_busy_fall", 32'(p_busy), 32'h0);
        check("stub_sig", p_sig, 32'h1F);
        check("stub_pass_golden", 32'(p_pass), 32'h1);
        check("stub_pass_wrong", 32'(f_pass), 32'h0);
        check("stub_sig_wrong", f_sig, 32'h1F);
      end
      start = (start_mid && c == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_end", 32'(m_busy), 32'h0);
    check("done_end", 32'(m_done), 32'h1);
    check("signature", m_sig, sig_exp);
    check("pass", 32'(m_pass), 32'(sig_exp == 32'h0));
    check("in1_done", m_in1, 32'h0);
    check("in2_done", m_in2, 32'h0);
    check("ctrl_done", 32'(m_ctrl), 32'h0);
    @(negedge clk);
    check("done_hold", 32'(m_done), 32'h1);
    check("sig_hold", m_sig, sig_exp);
    sig_got = m_sig;
  endtask

  initial begin
    logic [31:0] sig1, sig2, sig3, sigf;
    rst   = 1'b1;
    start = 1'b0;
    fault = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");

    start = 1'b1;
    @(negedge clk);
    check_idle("rst_and_start");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("idle");

    run_main(1'b0, 1'b0, 1'b1, sig1);
    run_main(1'b0, 1'b0, 1'b1, sig2);
    check("rerun_sig", sig2, sig1);
    run_main(1'b0, 1'b1, 1'b0, sig3);
    check("start_in_run_sig", sig3, sig1);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", 32'(m_busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("abort");
    @(negedge clk);
    check_idle("abort_hold");

    run_main(1'b1, 1'b0, 1'b0, sigf);
    check("fault_detected", 32'(sigf != sig1), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
